mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store per request from the MEM

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_access_unit_load_extend.sv | 43 ++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
//   - mem_op_e   : load/store operation encodings carried on req_op
//   - state_e    : access sequencer states
//   - MEM_BYTES_DEFAULT : default size of the data memory in bytes
//   - is_load / is_misaligned : small decode helpers shared by the top and sub-module
package mem_access_unit_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 16384;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic is_load(mem_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
        logic mis;
        case (op)
            OP_LW, OP_SW:         mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: selects the byte/halfword lane of a DM read word and extends it.
// Ports:
//   dm_rd_i  [31:0]  word read from data memory
//   op_i     [2:0]   operation (mem_op_e); stores yield 0
//   off_i    [1:0]   byte offset within the word (little-endian lanes)
//   data_o   [31:0]  sign- or zero-extended load result
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] dm_rd_i,
    input  mem_op_e     op_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm_rd_i[7:0];
        case (off_i)
            2'd0: byte_sel = dm_rd_i[7:0];
            2'd1: byte_sel = dm_rd_i[15:8];
            2'd2: byte_sel = dm_rd_i[23:16];
            2'd3: byte_sel = dm_rd_i[31:24];
            default: byte_sel = dm_rd_i[7:0];
        endcase
        half_sel = off_i[1] ? dm_rd_i[31:16] : dm_rd_i[15:0];
    end

    always_comb begin
        data_o = 32'd0;
        case (op_i)
            OP_LW:   data_o = dm_rd_i;
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'd0, half_sel};
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'd0, byte_sel};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the word-wide data-memory port.
// Takes one load/store at a time from the MEM stage, performs lane extraction
// for loads and a read-modify-write for byte/halfword stores.
//
// state  | meaning
// IDLE   | ready for a request (req_ready=1 when out of reset)
// ACCESS | DM read (loads, SB/SH) or whole-word write (SW)
// WRITE  | write-back of the merged word for SB/SH
// RESP   | one-cycle response pulse
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_op/req_addr/req_wdata/req_pc : request from MEM stage
//   resp_valid/resp_rdata/resp_exc                        : completion pulse
//   dm_we/dm_addr/dm_wd/dm_pc                             : DM drive
//   dm_rd                                                 : DM combinational read data
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    state_e      state_q;
    mem_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        exc_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    mem_op_e     req_op_e;
    logic        exc_d;
    logic [31:0] merge_d;
    logic [31:0] load_data;
    logic [31:0] word_addr;

    assign req_op_e  = mem_op_e'(req_op);
    assign exc_d     = is_misaligned(req_op_e, req_addr[1:0]) || (req_addr >= MEM_BYTES);
    assign word_addr = {addr_q[31:2], 2'b00};

    load_extend u_load_extend (
        .dm_rd_i (dm_rd),
        .op_i    (op_q),
        .off_i   (addr_q[1:0]),
        .data_o  (load_data)
    );

    // Sub-word store: keep every bit of the word read in ACCESS except the target lane.
    always_comb begin
        merge_d = dm_rd;
        if (op_q == OP_SB) begin
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (op_q == OP_SH) begin
            merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            exc_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        exc_q   <= exc_d;
                        rdata_q <= 32'd0;
                        state_q <= exc_d ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (is_load(op_q)) begin
                        rdata_q <= load_data;
                        state_q <= ST_RESP;
                    end else if (op_q == OP_SW) begin
                        state_q <= ST_RESP;
                    end else begin
                        merge_q <= merge_d;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: state_q <= ST_RESP;
                ST_RESP:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Gating with reset keeps the port quiet in the reset cycle itself,
    // before the state register has returned to IDLE.
    assign req_ready  = reset && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_exc   = resp_valid && exc_q;
    assign dm_we      = reset && (((state_q == ST_ACCESS) && (op_q == OP_SW)) ||
                                  (state_q == ST_WRITE));
    assign dm_addr    = (state_q == ST_IDLE) ? 32'd0 : word_addr;
    assign dm_pc      = (state_q == ST_IDLE) ? 32'd0 : pc_q;

    always_comb begin
        dm_wd = 32'd0;
        if (state_q == ST_WRITE) begin
            dm_wd = merge_q;
        end else if ((state_q == ST_ACCESS) && (op_q == OP_SW)) begin
            dm_wd = wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LHU = 3'd2;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] SW  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SB  = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    logic [31:0] mem [0:4095];

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wd      (dm_wd),
        .dm_pc      (dm_pc),
        .dm_rd      (dm_rd)
    );

    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr[13:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[13:2]] <= dm_wd;

    // Issues one request from a negedge, then watches up to 6 cycles for the response.
    // lat is the cycle index (1 = cycle after the accept edge) of resp_valid, -1 on timeout.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] pc, output int lat, output logic [31:0] rdata,
                           output logic exc, output int we_cnt, output int we_cyc,
                           output logic [31:0] we_data);
        lat = -1; rdata = 32'd0; exc = 1'b0; we_cnt = 0; we_cyc = -1; we_data = 32'd0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (dm_we) begin we_cnt++; we_cyc = c; we_data = dm_wd; end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; exc = resp_exc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_op = LW; req_addr = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready cyc%0d got=%b exp=0", i, req_ready); end
            checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we cyc%0d got=%b exp=0", i, dm_we); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid cyc%0d got=%b exp=0", i, resp_valid); end
            checks++; if (dm_addr !== 32'd0 || dm_pc !== 32'd0 || resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_outputs addr=%h pc=%h rdata=%h exp=0", dm_addr, dm_pc, resp_rdata); end
        end
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_loads();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic ex;
        logic [2:0]  t_op   [0:6] = '{LB, LBU, LH, LHU, LW, LB, LBU};
        logic [31:0] t_addr [0:6] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10};
        logic [31:0] t_exp  [0:6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                      32'h8899AABB, 32'hFFFFFF88, 32'h000000BB};
        run_req(SW, 32'h10, 32'h8899AABB, 32'h200, lat, rd, ex, wc, wcy, wdat);
        checks++; if (lat !== 2 || wc !== 1 || wcy !== 1) begin errors++; $display("FAIL preload_sw lat=%0d we_cnt=%0d we_cyc=%0d exp 2/1/1", lat, wc, wcy); end
        for (int i = 0; i < 7; i++) begin
            run_req(t_op[i], t_addr[i], 32'd0, 32'h300 + i, lat, rd, ex, wc, wcy, wdat);
            checks++; if (lat !== 2) begin errors++; $display("FAIL load%0d_latency got=%0d exp=2", i, lat); end
            checks++; if (rd !== t_exp[i]) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, t_exp[i]); end
            checks++; if (ex !== 1'b0 || wc !== 0) begin errors++; $display("FAIL load%0d_side exc=%b we_cnt=%0d exp 0/0", i, ex, wc); end
        end
    endtask

    task automatic test_sub_store();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic ex;
        run_req(SW, 32'h20, 32'h11223344, 32'h400, lat, rd, ex, wc, wcy, wdat);
        run_req(SB, 32'h21, 32'h000000FF, 32'h404, lat, rd, ex, wc, wcy, wdat);
        checks++; if (wc !== 1 || wcy !== 2) begin errors++; $display("FAIL sb_we we_cnt=%0d we_cyc=%0d exp 1/2", wc, wcy); end
        checks++; if (wdat !== 32'h1122FF44) begin errors++; $display("FAIL sb_wd got=%h exp=1122ff44", wdat); end
        checks++; if (lat !== 3 || rd !== 32'd0 || ex !== 1'b0) begin errors++; $display("FAIL sb_resp lat=%0d rdata=%h exc=%b exp 3/0/0", lat, rd, ex); end
        run_req(LW, 32'h20, 32'd0, 32'h408, lat, rd, ex, wc, wcy, wdat);
        checks++; if (rd !== 32'h1122FF44) begin errors++; $display("FAIL sb_readback got=%h exp=1122ff44", rd); end
        run_req(SH, 32'h22, 32'h5555ABCD, 32'h40C, lat, rd, ex, wc, wcy, wdat);
        checks++; if (wdat !== 32'hABCDFF44 || lat !== 3 || wc !== 1) begin errors++; $display("FAIL sh_hi wd=%h lat=%0d we_cnt=%0d exp abcdff44/3/1", wdat, lat, wc); end
        run_req(SB, 32'h23, 32'hAAAAAA77, 32'h410, lat, rd, ex, wc, wcy, wdat);
        checks++; if (wdat !== 32'h77CDFF44) begin errors++; $display("FAIL sb_lane3 got=%h exp=77cdff44", wdat); end
        run_req(SH, 32'h20, 32'h00009876, 32'h414, lat, rd, ex, wc, wcy, wdat);
        checks++; if (wdat !== 32'h77CD9876) begin errors++; $display("FAIL sh_lo got=%h exp=77cd9876", wdat); end
        run_req(LW, 32'h20, 32'd0, 32'h418, lat, rd, ex, wc, wcy, wdat);
        checks++; if (rd !== 32'h77CD9876) begin errors++; $display("FAIL sub_readback got=%h exp=77cd9876", rd); end
    endtask

    task automatic test_exc();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic ex;
        logic [2:0]  t_op   [0:4] = '{SW, LH, LW, SH, SB};
        logic [31:0] t_addr [0:4] = '{32'h32, 32'h41, 32'h4000, 32'h43, 32'h4000};
        for (int i = 0; i < 5; i++) begin
            run_req(t_op[i], t_addr[i], 32'hDEADBEEF, 32'h500, lat, rd, ex, wc, wcy, wdat);
            checks++; if (lat !== 1 || ex !== 1'b1) begin errors++; $display("FAIL exc%0d lat=%0d exc=%b exp 1/1", i, lat, ex); end
            checks++; if (wc !== 0 || rd !== 32'd0) begin errors++; $display("FAIL exc%0d_side we_cnt=%0d rdata=%h exp 0/0", i, wc, rd); end
        end
        run_req(SW, 32'h3FFC, 32'h0BADCAFE, 32'h504, lat, rd, ex, wc, wcy, wdat);
        checks++; if (lat !== 2 || ex !== 1'b0 || wc !== 1) begin errors++; $display("FAIL top_word_sw lat=%0d exc=%b we_cnt=%0d exp 2/0/1", lat, ex, wc); end
        run_req(LW, 32'h3FFC, 32'd0, 32'h508, lat, rd, ex, wc, wcy, wdat);
        checks++; if (rd !== 32'h0BADCAFE || ex !== 1'b0) begin errors++; $display("FAIL top_word_lw rdata=%h exc=%b exp 0badcafe/0", rd, ex); end
    endtask

    task automatic test_back_to_back();
        logic rdy_exp [1:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic rv_exp  [1:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h0; req_wdata = 32'hCAFEF00D; req_pc = 32'h100;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_initial got=%b exp=1", req_ready); end
        @(posedge clk);
        #1 req_op = LW; req_wdata = 32'd0; req_pc = 32'h104;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== rdy_exp[c]) begin errors++; $display("FAIL b2b_ready cyc%0d got=%b exp=%b", c, req_ready, rdy_exp[c]); end
            checks++; if (resp_valid !== rv_exp[c]) begin errors++; $display("FAIL b2b_resp_valid cyc%0d got=%b exp=%b", c, resp_valid, rv_exp[c]); end
            if (c == 1) begin
                checks++; if (dm_we !== 1'b1 || dm_pc !== 32'h100) begin errors++; $display("FAIL b2b_sw_drive we=%b pc=%h exp 1/100", dm_we, dm_pc); end
            end
            if (c == 5) begin
                checks++; if (resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw_rdata got=%h exp=cafef00d", resp_rdata); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, wc, wcy, stray; logic [31:0] rd, wdat; logic ex;
        run_req(SW, 32'h50, 32'hDEADBEEF, 32'h600, lat, rd, ex, wc, wcy, wdat);
        @(negedge clk);
        req_valid = 1'b1; req_op = SH; req_addr = 32'h52; req_wdata = 32'h00001234; req_pc = 32'h604;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dm_we !== 1'b1 || dm_wd !== 32'h1234BEEF) begin errors++; $display("FAIL rmid_write_state we=%b wd=%h exp 1/1234beef", dm_we, dm_wd); end
        reset = 1'b0;
        #1;
        checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rmid_we_gated got=%b exp=0", dm_we); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle ready=%b resp_valid=%b exp 1/0", req_ready, resp_valid); end
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_no_resp got=%0d pulses exp=0", stray); end
        checks++; if (mem[20] !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_mem got=%h exp=deadbeef", mem[20]); end
        run_req(LW, 32'h50, 32'd0, 32'h608, lat, rd, ex, wc, wcy, wdat);
        checks++; if (rd !== 32'hDEADBEEF || lat !== 2) begin errors++; $display("FAIL rmid_readback rdata=%h lat=%0d exp deadbeef/2", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_store();
        test_exc();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
